// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and types for the RV32I main decoder.
//   - opcode constants for the five supported instruction groups
//   - func7 constants for the base and alternate (SUB/SRA) encodings
//   - alu_op_e: 4-bit ALU operation codes driven on alu_control
//   - op_class_e: opcode class handed from control_unit to alu_decoder
//   - base_alu_op(): func3 -> ALU op for the base (func7 = 0) encodings
package ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_IALU   = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } op_class_e;

    // ALU operation selected by func3 when func7 carries the base encoding.
    // Shared by R-type and I-ALU; the alternate forms are handled by the caller.
    function automatic alu_op_e base_alu_op(input logic [2:0] func3);
        alu_op_e op;
        case (func3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational mapping of (opcode class, func3, func7) to the
// ALU operation and a legality bit.
// Ports:
//   op_class    in  3  opcode class from control_unit
//   func3       in  3  instr[14:12]
//   func7       in  7  instr[31:25]
//   alu_control out 4  ALU operation (ADD whenever the encoding is illegal)
//   illegal     out 1  encoding is not supported for this class
module alu_decoder
    import ctrl_pkg::*;
(
    input  op_class_e   op_class,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    output logic [3:0]  alu_control,
    output logic        illegal
);

    alu_op_e op;
    logic    bad;

    always_comb begin
        op  = ALU_ADD;
        bad = 1'b0;
        case (op_class)
            CLS_RTYPE: begin
                if (func7 == F7_BASE) begin
                    op = base_alu_op(func3);
                end else if (func7 == F7_ALT && func3 == 3'b000) begin
                    op = ALU_SUB;
                end else if (func7 == F7_ALT && func3 == 3'b101) begin
                    op = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            CLS_IALU: begin
                // func7 only matters for the shifts; it is immediate bits otherwise.
                case (func3)
                    3'b001: begin
                        op  = ALU_SLL;
                        bad = (func7 != F7_BASE);
                    end
                    3'b101: begin
                        if (func7 == F7_BASE) begin
                            op = ALU_SRL;
                        end else if (func7 == F7_ALT) begin
                            op = ALU_SRA;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: op = base_alu_op(func3);
                endcase
            end
            CLS_LOAD: begin
                // LB, LH, LW, LBU, LHU
                bad = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
            end
            CLS_STORE: begin
                // SB, SH, SW
                bad = (func3 > 3'b010);
            end
            CLS_BRANCH: begin
                case (func3)
                    3'b000, 3'b001: op  = ALU_SUB;
                    3'b100, 3'b101: op  = ALU_SLT;
                    3'b110, 3'b111: op  = ALU_SLTU;
                    default:        bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            op = ALU_ADD;
        end
    end

    assign alu_control = op;
    assign illegal     = bad;

endmodule

// File: rtl/control_unit.sv
// control_unit: main decoder for the single-cycle RV32I core.
// Decode is combinational; only the sticky illegal flag (and the optional
// instruction counter) are registered.
// Optional build macro: CTRL_STATS_EN adds instr_count, a wrapping 32-bit
// count of clock cycles that carried a legal encoding while out of reset.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   opcode/func3/func7    instruction fields
//   alu_control           ALU operation code
//   reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src  strobes
//   illegal_instr         current encoding unsupported (combinational)
//   illegal_seen          sticky: an illegal encoding was decoded since reset
//   instr_count           (CTRL_STATS_EN only) legal-instruction counter
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    output logic [3:0]  alu_control,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        illegal_instr,
    output logic        illegal_seen
`ifdef CTRL_STATS_EN
    ,
    output logic [31:0] instr_count
`endif
);

    op_class_e  op_class;
    logic [3:0] dec_alu;
    logic       dec_illegal;

    always_comb begin
        case (opcode)
            OPC_RTYPE:  op_class = CLS_RTYPE;
            OPC_IALU:   op_class = CLS_IALU;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            default:    op_class = CLS_NONE;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op_class    (op_class),
        .func3       (func3),
        .func7       (func7),
        .alu_control (dec_alu),
        .illegal     (dec_illegal)
    );

    // Strobes are only raised for a legal encoding out of reset, so an
    // illegal instruction can never write a register or touch memory.
    always_comb begin
        alu_control   = 4'b0000;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch        = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        illegal_instr = 1'b0;
        if (rst_n) begin
            illegal_instr = dec_illegal;
            if (!dec_illegal) begin
                alu_control = dec_alu;
                case (op_class)
                    CLS_RTYPE: begin
                        reg_write = 1'b1;
                    end
                    CLS_IALU: begin
                        reg_write = 1'b1;
                        alu_src   = 1'b1;
                    end
                    CLS_LOAD: begin
                        reg_write  = 1'b1;
                        mem_read   = 1'b1;
                        mem_to_reg = 1'b1;
                        alu_src    = 1'b1;
                    end
                    CLS_STORE: begin
                        mem_write = 1'b1;
                        alu_src   = 1'b1;
                    end
                    CLS_BRANCH: begin
                        branch = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reset has priority over a simultaneous set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_seen <= 1'b0;
        end else if (illegal_instr) begin
            illegal_seen <= 1'b1;
        end
    end

`ifdef CTRL_STATS_EN
    // Natural 32-bit wrap from 0xFFFFFFFF to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_count <= 32'd0;
        end else if (!illegal_instr) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed test-plan steps followed by random encodings,
// each checked against a rule-level reference model of the decoder.
module tb_control_unit;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [3:0]  alu_control;
    logic        reg_write, mem_read, mem_write, branch;
    logic        mem_to_reg, alu_src, illegal_instr, illegal_seen;
`ifdef CTRL_STATS_EN
    logic [31:0] instr_count;
`endif

    always #5 clk = ~clk;

    control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .func3         (func3),
        .func7         (func7),
        .alu_control   (alu_control),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch        (branch),
        .mem_to_reg    (mem_to_reg),
        .alu_src       (alu_src),
        .illegal_instr (illegal_instr),
        .illegal_seen  (illegal_seen)
`ifdef CTRL_STATS_EN
        ,
        .instr_count   (instr_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [10:0] exp_q[$];     // {alu[3:0], rw, mr, mw, br, m2r, src, ill}
    bit          seen_known = 0;
    bit          model_seen = 0;
    logic [31:0] model_count = 0;

    // ---------------- reference model ----------------
    // Written from the instruction-set rules: which (opcode, func3, func7)
    // triples are legal, what each computes, and which strobes each group uses.
    function automatic logic [10:0] model(bit rst_ok, logic [6:0] opc,
                                          logic [2:0] f3, logic [6:0] f7);
        logic [3:0] tbl [8];
        logic [3:0] alu;
        bit ok, rw, mr, mw, br, m2r, src;
        // base-encoding op per func3: ADD SLL SLT SLTU XOR SRL OR AND
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        alu = 4'd0; ok = 0;
        rw = 0; mr = 0; mw = 0; br = 0; m2r = 0; src = 0;
        if (!rst_ok) return 11'd0;
        if (opc == 7'h33) begin
            ok  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            alu = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'd1 : 4'd7) : tbl[f3];
            rw  = 1;
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1)      ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            else                 ok = 1;
            alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : tbl[f3];
            rw  = 1; src = 1;
        end else if (opc == 7'h03) begin
            ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
            rw = 1; mr = 1; m2r = 1; src = 1;
        end else if (opc == 7'h23) begin
            ok = (f3 <= 3'd2);
            mw = 1; src = 1;
        end else if (opc == 7'h63) begin
            ok  = !(f3 == 3'd2 || f3 == 3'd3);
            alu = (f3 < 3'd2) ? 4'd1 : (f3 < 3'd6) ? 4'd8 : 4'd9;
            br  = 1;
        end
        if (!ok) return 11'b0000_000000_1;
        return {alu, rw, mr, mw, br, m2r, src, 1'b0};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one instruction for one cycle: checks the combinational decode and
    // the registered outputs before the edge, then advances the model state.
    task automatic step(bit r, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
        logic [10:0] e;
        logic [10:0] obs;
        @(negedge clk);
        rst_n = r; opcode = opc; func3 = f3; func7 = f7;
        #1;
        exp_q.push_back(model(r, opc, f3, f7));
        e   = exp_q.pop_front();
        obs = {alu_control, reg_write, mem_read, mem_write, branch,
               mem_to_reg, alu_src, illegal_instr};
        check($sformatf("decode opc=%b f3=%b f7=%b rst_n=%0d", opc, f3, f7, r),
              {21'd0, obs}, {21'd0, e});
        if (seen_known) begin
            check("illegal_seen", {31'd0, illegal_seen}, {31'd0, model_seen});
`ifdef CTRL_STATS_EN
            check("instr_count", instr_count, model_count);
`endif
        end
        @(posedge clk);
        if (!r) begin
            model_seen  = 0;
            model_count = 0;
            seen_known  = 1;
        end else if (seen_known) begin
            if (e[0]) model_seen = 1;
            else      model_count = model_count + 1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] opcs [5];
        logic [6:0] o, f7v;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
        rst_n = 0; opcode = 7'h33; func3 = 0; func7 = 0;

        step(0, 7'h33, 3'b000, 7'h00);          // reset: all outputs 0
        step(1, 7'h33, 3'b000, 7'h00);          // R ADD
        step(1, 7'h33, 3'b000, 7'h20);          // R SUB
        step(1, 7'h33, 3'b101, 7'h20);          // R SRA
        step(1, 7'h33, 3'b000, 7'h01);          // illegal func7
        step(1, 7'h13, 3'b000, 7'h20);          // ADDI ignores func7; seen now 1
        step(1, 7'h13, 3'b101, 7'h20);          // SRAI
        step(1, 7'h13, 3'b001, 7'h20);          // SLLI bad func7
        step(1, 7'h03, 3'b010, 7'h00);          // LW
        step(1, 7'h03, 3'b011, 7'h00);          // bad load width
        step(1, 7'h23, 3'b010, 7'h00);          // SW
        step(1, 7'h23, 3'b011, 7'h00);          // bad store width
        step(1, 7'h63, 3'b110, 7'h00);          // BLTU
        step(1, 7'h63, 3'b010, 7'h00);          // bad branch
        step(1, 7'h7f, 3'b000, 7'h00);          // unknown opcode
        step(0, 7'h7f, 3'b000, 7'h00);          // reset masks illegal, seen still 1
        step(1, 7'h33, 3'b111, 7'h00);          // seen cleared; AND

        for (int i = 0; i < 400; i++) begin
            o = ($urandom_range(0, 5) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 4)];
            case ($urandom_range(0, 3))
                0, 1:    f7v = 7'h00;
                2:       f7v = 7'h20;
                default: f7v = 7'($urandom);
            endcase
            step($urandom_range(0, 39) != 0, o, 3'($urandom), f7v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
